// File: rtl/frame_top2_feeder.sv
// Buffers a valid/ready framed sample stream and replays each frame into a
// free-running second-largest tracker, returning one (value, count) result per frame.
module frame_top2_feeder #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_last,
    output logic [DATA_WIDTH-1:0] trk_din,
    output logic                  trk_clr_n,
    input  logic [DATA_WIDTH-1:0] trk_dout,
    output logic                  r_valid,
    input  logic                  r_ready,
    output logic [DATA_WIDTH-1:0] r_data,
    output logic [CNT_WIDTH-1:0]  r_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]          PTR_ONE = 1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

    typedef enum logic [2:0] {CLEAR, STREAM, FLUSH, CAPTURE, RESULT} state_t;
    state_t state;

    // Each entry is {last, data}; pointers carry one extra wrap bit.
    logic [DATA_WIDTH:0]  mem [FIFO_DEPTH];
    logic [AW:0]          wr_ptr;
    logic [AW:0]          rd_ptr;
    logic                 full;
    logic                 empty;
    logic                 push;
    logic                 pop;
    logic [DATA_WIDTH:0]  head;
    logic [CNT_WIDTH-1:0] cnt;

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign s_ready   = !full;
    assign push      = s_valid && !full;
    assign pop       = (state == STREAM) && !empty;
    assign head      = mem[rd_ptr[AW-1:0]];
    assign trk_clr_n = (state != CLEAR);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= {s_last, s_data};
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    // Idle cycles feed zero, which can never raise the tracker's maximum.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= CLEAR;
            trk_din <= '0;
            cnt     <= '0;
            r_valid <= 1'b0;
            r_data  <= '0;
            r_count <= '0;
        end else begin
            trk_din <= pop ? head[DATA_WIDTH-1:0] : '0;
            case (state)
                CLEAR: begin
                    cnt   <= '0;
                    state <= STREAM;
                end
                STREAM: begin
                    if (pop) begin
                        if (cnt != '1) begin
                            cnt <= cnt + CNT_ONE;
                        end
                        if (head[DATA_WIDTH]) begin
                            state <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    state <= CAPTURE;
                end
                CAPTURE: begin
                    r_data  <= trk_dout;
                    r_count <= cnt;
                    r_valid <= 1'b1;
                    state   <= RESULT;
                end
                RESULT: begin
                    if (r_ready) begin
                        r_valid <= 1'b0;
                        state   <= CLEAR;
                    end
                end
                default: begin
                    state <= CLEAR;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_frame_top2_feeder.sv
// Bench for frame_top2_feeder: directed scenarios plus random frames, with a
// stand-in second-largest tracker and a frame-level reference model.
module tb_frame_top2_feeder;
    localparam int DW   = 32;
    localparam int FD   = 8;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [DW-1:0] s_data = '0;
    logic          s_last = 1'b0;
    logic [DW-1:0] trk_din;
    logic          trk_clr_n;
    logic [DW-1:0] trk_dout;
    logic          r_valid;
    logic          r_ready = 1'b0;
    logic [DW-1:0] r_data;
    logic [CW-1:0] r_count;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    frame_top2_feeder #(.DATA_WIDTH(DW), .FIFO_DEPTH(FD), .CNT_WIDTH(CW)) dut (
        .clk(clk), .resetn(resetn), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .s_last(s_last), .trk_din(trk_din), .trk_clr_n(trk_clr_n),
        .trk_dout(trk_dout), .r_valid(r_valid), .r_ready(r_ready),
        .r_data(r_data), .r_count(r_count)
    );

    // Stand-in tracker: a new maximum pushes the old maximum into the second slot.
    logic [DW-1:0] trk_max = '0;
    logic [DW-1:0] trk_sec = '0;
    always @(posedge clk) begin
        if (!trk_clr_n) begin
            trk_max <= '0;
            trk_sec <= '0;
        end else if (trk_din > trk_max) begin
            trk_sec <= trk_max;
            trk_max <= trk_din;
        end
    end
    assign trk_dout = trk_sec;

    // Reference model: second = largest value before the first occurrence of the frame max.
    logic [DW-1:0]    cur_q[$];
    logic [DW+CW-1:0] exp_q[$];

    function automatic logic [DW+CW-1:0] frame_result();
        logic [DW-1:0] m;
        logic [DW-1:0] sec;
        int k;
        int n;
        m = '0;
        sec = '0;
        k = 0;
        n = cur_q.size();
        foreach (cur_q[i]) if (cur_q[i] > m) m = cur_q[i];
        for (int i = n - 1; i >= 0; i--) if (cur_q[i] == m) k = i;
        for (int i = 0; i < k; i++) if (cur_q[i] > sec) sec = cur_q[i];
        if (n > CMAX) n = CMAX;
        return {sec, CW'(n)};
    endfunction

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cur_q.delete();
            exp_q.delete();
        end else if (s_valid && s_ready) begin
            cur_q.push_back(s_data);
            if (s_last) begin
                exp_q.push_back(frame_result());
                cur_q.delete();
            end
        end
    end

    logic          log_en = 1'b0;
    logic [DW-1:0] din_log[$];
    logic          rv_log[$];
    logic          clr_log[$];
    logic [DW-1:0] want_q[$];

    always @(negedge clk) begin
        if (log_en) begin
            din_log.push_back(trk_din);
            rv_log.push_back(r_valid);
            clr_log.push_back(trk_clr_n);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_log();
        din_log.delete();
        rv_log.delete();
        clr_log.delete();
        log_en = 1'b1;
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input logic l);
        int n;
        n = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        while (!s_ready && n < 400) begin
            tick();
            n++;
        end
        if (!s_ready) check("send_ready", 64'(s_ready), 64'd1);
        tick();
        s_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        s_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic get_result(input string tag, input int dly, input logic use_c,
                              input logic [DW-1:0] cd, input logic [CW-1:0] cc);
        int n;
        logic [DW+CW-1:0] e;
        n = 0;
        while (!r_valid && n < 600) begin
            tick();
            n++;
        end
        check({tag, "_valid"}, 64'(r_valid), 64'd1);
        if (r_valid) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            if (use_c) e = {cd, cc};
            check({tag, "_data"}, 64'(r_data), 64'(e[DW+CW-1:CW]));
            check({tag, "_count"}, 64'(r_count), 64'(e[CW-1:0]));
            repeat (dly) begin
                tick();
                check({tag, "_hold"}, 64'({r_valid, r_data, r_count}), 64'({1'b1, e}));
            end
            r_ready = 1'b1;
            tick();
            r_ready = 1'b0;
            check({tag, "_drop"}, 64'(r_valid), 64'd0);
        end
    endtask

    task automatic check_din(input string tag);
        int j;
        j = 0;
        foreach (din_log[i]) begin
            if (din_log[i] != '0) begin
                if (j < want_q.size()) check(tag, 64'(din_log[i]), 64'(want_q[j]));
                j++;
            end
        end
        check({tag, "_n"}, 64'(j), 64'(want_q.size()));
    endtask

    function automatic int clr_lows();
        int z;
        z = 0;
        foreach (clr_log[i]) if (clr_log[i] == 1'b0) z++;
        return z;
    endfunction

    function automatic int find_din(input logic [DW-1:0] v);
        int idx;
        idx = -1;
        for (int i = din_log.size() - 1; i >= 0; i--) if (din_log[i] == v) idx = i;
        return idx;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        logic saw;

        // Reset values
        repeat (3) tick();
        check("rst_s_ready", 64'(s_ready), 64'd1);
        check("rst_clr_n", 64'(trk_clr_n), 64'd0);
        check("rst_trk_din", 64'(trk_din), 64'd0);
        check("rst_r_valid", 64'(r_valid), 64'd0);
        check("rst_r_data", 64'(r_data), 64'd0);
        check("rst_r_count", 64'(r_count), 64'd0);

        // Contiguous frame right after reset; tracker cleared for exactly one cycle
        start_log();
        resetn = 1'b1;
        send_beat(5, 1'b0);
        send_beat(9, 1'b0);
        send_beat(3, 1'b0);
        send_beat(12, 1'b1);
        get_result("t1", 2, 1'b1, 9, 4);
        log_en = 1'b0;
        check("t1_clr_first", 64'(clr_log[0]), 64'd0);
        check("t1_clr_second", 64'(clr_log[1]), 64'd1);
        check("t1_clr_cycles", 64'(clr_lows()), 64'd1);
        want_q = '{5, 9, 3, 12};
        check_din("t1_din");

        // Back-to-back frames separated only by CLEAR
        start_log();
        send_beat(7, 1'b0);
        send_beat(3, 1'b1);
        send_beat(1, 1'b0);
        send_beat(2, 1'b0);
        send_beat(4, 1'b1);
        get_result("t2a", 0, 1'b1, 0, 2);
        get_result("t2b", 0, 1'b1, 2, 3);
        log_en = 1'b0;
        check("t2_clr_cycles", 64'(clr_lows()), 64'd2);
        want_q = '{7, 3, 1, 2, 4};
        check_din("t2_din");

        // Result stalled while the FIFO fills; release and drain
        fork
            begin
                send_beat(15, 1'b0);
                send_beat(40, 1'b1);
                for (int i = 0; i < 10; i++) send_beat(DW'($urandom_range(1, 1000)), i == 9);
            end
            begin
                saw = 1'b0;
                for (int i = 0; i < 200 && !saw; i++) begin
                    @(negedge clk);
                    if (s_valid && !s_ready) saw = 1'b1;
                end
                tick();
                check("t3_full", 64'(saw), 64'd1);
                get_result("t3a", 4, 1'b1, 15, 2);
                get_result("t3b", 2, 1'b0, '0, '0);
            end
        join

        // Single-sample frame and its result latency
        start_log();
        send_beat(42, 1'b1);
        get_result("t4", 0, 1'b1, 0, 1);
        log_en = 1'b0;
        idx = find_din(42);
        check("t4_found", 64'(idx >= 0), 64'd1);
        if (idx >= 0 && idx + 2 < rv_log.size()) begin
            check("t4_lat0", 64'(rv_log[idx]), 64'd0);
            check("t4_lat1", 64'(rv_log[idx+1]), 64'd0);
            check("t4_lat2", 64'(rv_log[idx+2]), 64'd1);
        end

        // Ingress gaps produce neutral zero cycles
        start_log();
        idle(2);
        send_beat(10, 1'b0);
        idle(1);
        send_beat(20, 1'b0);
        idle(1);
        send_beat(30, 1'b1);
        get_result("t5", 0, 1'b1, 20, 3);
        log_en = 1'b0;
        idx = find_din(10);
        check("t5_found", 64'(idx >= 0), 64'd1);
        want_q = '{10, 0, 20, 0, 30};
        if (idx >= 0 && idx + 4 < din_log.size()) begin
            for (int i = 0; i < 5; i++) check("t5_gap", 64'(din_log[idx+i]), 64'(want_q[i]));
        end

        // Reset mid-frame discards the partial frame
        send_beat(100, 1'b0);
        send_beat(200, 1'b0);
        idle(3);
        resetn = 1'b0;
        tick();
        check("t6_s_ready", 64'(s_ready), 64'd1);
        check("t6_clr_n", 64'(trk_clr_n), 64'd0);
        check("t6_trk_din", 64'(trk_din), 64'd0);
        check("t6_r_valid", 64'(r_valid), 64'd0);
        check("t6_r_data", 64'(r_data), 64'd0);
        check("t6_r_count", 64'(r_count), 64'd0);
        tick();
        resetn = 1'b1;
        send_beat(6, 1'b0);
        send_beat(8, 1'b1);
        get_result("t6", 0, 1'b1, 6, 2);
        check("t6_no_extra", 64'(exp_q.size()), 64'd0);

        // Long frame saturates the sample counter
        for (int i = 1; i <= 20; i++) send_beat(DW'(i), i == 20);
        get_result("t7", 1, 1'b1, 19, 4'hF);

        // Random frames with random gaps and random result back-pressure
        fork
            begin
                for (int f = 0; f < 25; f++) begin
                    int len;
                    len = $urandom_range(1, 6);
                    for (int j = 0; j < len; j++) begin
                        send_beat(DW'($urandom_range(0, 63)), j == len - 1);
                        if ($urandom_range(0, 3) == 0) idle(1);
                    end
                end
            end
            begin
                for (int f = 0; f < 25; f++) get_result("rnd", $urandom_range(0, 3), 1'b0, '0, '0);
            end
        join

        check("end_exp_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
